// File: rtl/axis_argmax_fp32.sv
// Streaming argmax over VEC_LEN FP32 scores; emits the index of the largest element.
// Optional macro ARGMAX_VALUE_EN adds a second result beat carrying the maximum FP32 value.
module axis_argmax_fp32 #(
    parameter int VEC_LEN = 4,
    parameter int IDX_W   = $clog2(VEC_LEN)
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] INPUT_AXIS_TDATA,
    input  logic        INPUT_AXIS_TLAST,
    input  logic        INPUT_AXIS_TVALID,
    output logic        INPUT_AXIS_TREADY,
    output logic [31:0] OUTPUT_AXIS_TDATA,
    output logic        OUTPUT_AXIS_TLAST,
    output logic        OUTPUT_AXIS_TVALID,
    input  logic        OUTPUT_AXIS_TREADY
);

    typedef enum logic [1:0] {SCAN, EMIT_IDX, EMIT_VAL} state_t;

    // Maps FP32 bit patterns onto an unsigned total order (NaNs land beyond the infinities).
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

`ifdef ARGMAX_VALUE_EN
    function automatic logic [31:0] fp_unkey(input logic [31:0] k);
        return k[31] ? (k ^ 32'h8000_0000) : ~k;
    endfunction
`endif

    state_t             state, state_nx;
    logic [IDX_W-1:0]   count, count_nx;
    logic [31:0]        best_key, best_key_nx;
    logic [IDX_W-1:0]   best_idx, best_idx_nx;
    logic               in_rdy, in_rdy_nx;
    logic               out_vld, out_vld_nx;
    logic [31:0]        out_data, out_data_nx;
    logic               out_last, out_last_nx;

    logic               in_hs;
    logic               eof;
    logic               take;
    logic [31:0]        in_key;
    logic [31:0]        cand_key;
    logic [IDX_W-1:0]   cand_idx;

    assign in_hs    = INPUT_AXIS_TVALID & in_rdy;
    assign eof      = (count == IDX_W'(VEC_LEN - 1)) | INPUT_AXIS_TLAST;
    assign in_key   = fp_key(INPUT_AXIS_TDATA);
    // First beat of a frame seeds the running best; later beats need a strict win so ties keep the lower index.
    assign take     = (count == '0) || (in_key > best_key);
    assign cand_key = take ? in_key : best_key;
    assign cand_idx = take ? count : best_idx;

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        best_key_nx = best_key;
        best_idx_nx = best_idx;
        in_rdy_nx   = in_rdy;
        out_vld_nx  = out_vld;
        out_data_nx = out_data;
        out_last_nx = out_last;
        case (state)
            SCAN: begin
                in_rdy_nx = 1'b1;
                if (in_hs) begin
                    best_key_nx = cand_key;
                    best_idx_nx = cand_idx;
                    if (eof) begin
                        state_nx    = EMIT_IDX;
                        count_nx    = '0;
                        in_rdy_nx   = 1'b0;
                        out_vld_nx  = 1'b1;
                        out_data_nx = 32'(cand_idx);
`ifdef ARGMAX_VALUE_EN
                        out_last_nx = 1'b0;
`else
                        out_last_nx = 1'b1;
`endif
                    end else begin
                        count_nx = count + IDX_W'(1);
                    end
                end
            end
            EMIT_IDX: begin
                if (OUTPUT_AXIS_TREADY) begin
`ifdef ARGMAX_VALUE_EN
                    state_nx    = EMIT_VAL;
                    out_data_nx = fp_unkey(best_key);
                    out_last_nx = 1'b1;
`else
                    state_nx    = SCAN;
                    out_vld_nx  = 1'b0;
                    out_last_nx = 1'b0;
                    in_rdy_nx   = 1'b1;
`endif
                end
            end
`ifdef ARGMAX_VALUE_EN
            EMIT_VAL: begin
                if (OUTPUT_AXIS_TREADY) begin
                    state_nx    = SCAN;
                    out_vld_nx  = 1'b0;
                    out_last_nx = 1'b0;
                    in_rdy_nx   = 1'b1;
                end
            end
`endif
            default: begin
                state_nx   = SCAN;
                out_vld_nx = 1'b0;
                in_rdy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= SCAN;
            count    <= '0;
            best_key <= '0;
            best_idx <= '0;
            in_rdy   <= 1'b0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            best_key <= best_key_nx;
            best_idx <= best_idx_nx;
            in_rdy   <= in_rdy_nx;
            out_vld  <= out_vld_nx;
            out_data <= out_data_nx;
            out_last <= out_last_nx;
        end
    end

    assign INPUT_AXIS_TREADY  = in_rdy;
    assign OUTPUT_AXIS_TVALID = out_vld;
    assign OUTPUT_AXIS_TDATA  = out_data;
    assign OUTPUT_AXIS_TLAST  = out_last;

endmodule

// File: tb/tb_axis_argmax_fp32.sv
// Directed bench for axis_argmax_fp32 (VEC_LEN=4) with hand-computed FP32 argmax results.
module tb_axis_argmax_fp32;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] in_tdata;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast;
    logic        out_tvalid;
    logic        out_tready;

    int n_checks = 0;
    int n_fail   = 0;

    axis_argmax_fp32 #(.VEC_LEN(4)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .INPUT_AXIS_TDATA   (in_tdata),
        .INPUT_AXIS_TLAST   (in_tlast),
        .INPUT_AXIS_TVALID  (in_tvalid),
        .INPUT_AXIS_TREADY  (in_tready),
        .OUTPUT_AXIS_TDATA  (out_tdata),
        .OUTPUT_AXIS_TLAST  (out_tlast),
        .OUTPUT_AXIS_TVALID (out_tvalid),
        .OUTPUT_AXIS_TREADY (out_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input string tag, input logic [31:0] d, input logic last);
        int t = 0;
        while (!in_tready && t < 50) begin
            tick();
            t++;
        end
        check_eq({tag, "_rdy"}, 32'(in_tready), 32'd1);
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // Frames shorter than 4 close with TLAST; full frames omit TLAST and close by count.
    task automatic send_frame(input string tag, input logic [31:0] f [4], input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            send_beat(tag, f[i], (n < 4) && (i == n - 1));
            if (i < n - 1) repeat (gap) tick();
        end
        check_eq({tag, "_lat"}, 32'(out_tvalid), 32'd1);
    endtask

    task automatic get_result(input string tag, input logic [31:0] idx, input logic [31:0] val);
        int t = 0;
        $display("%s: expecting index %0d, max value %h", tag, idx, val);
        while (!out_tvalid && t < 20) begin
            tick();
            t++;
        end
        check_eq({tag, "_vld"}, 32'(out_tvalid), 32'd1);
        check_eq({tag, "_idx"}, out_tdata, idx);
`ifdef ARGMAX_VALUE_EN
        check_eq({tag, "_last0"}, 32'(out_tlast), 32'd0);
        tick();
        check_eq({tag, "_vld1"}, 32'(out_tvalid), 32'd1);
        check_eq({tag, "_val"}, out_tdata, val);
        check_eq({tag, "_last1"}, 32'(out_tlast), 32'd1);
`else
        check_eq({tag, "_last"}, 32'(out_tlast), 32'd1);
`endif
        tick();
        check_eq({tag, "_done"}, 32'(out_tvalid), 32'd0);
        check_eq({tag, "_rdy_back"}, 32'(in_tready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fr [4];
        int seen;

        aresetn    = 1'b0;
        in_tdata   = '0;
        in_tlast   = 1'b0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        repeat (3) tick();
        check_eq("rst_in_rdy", 32'(in_tready), 32'd0);
        check_eq("rst_vld", 32'(out_tvalid), 32'd0);
        check_eq("rst_data", out_tdata, 32'd0);
        check_eq("rst_last", 32'(out_tlast), 32'd0);
        aresetn = 1'b1;
        check_eq("rel_in_rdy", 32'(in_tready), 32'd0);
        tick();
        check_eq("rdy_rise", 32'(in_tready), 32'd1);

        // 9, 10, 11, 12
        fr = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000};
        send_frame("basic", fr, 4, 0);
        get_result("basic", 32'd3, 32'h4140_0000);

        // 2, 5, 5, 1: tie keeps lower index
        fr = '{32'h4000_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h3F80_0000};
        send_frame("tie", fr, 4, 0);
        get_result("tie", 32'd1, 32'h40A0_0000);

        // -3, -1.5, -2, -8
        fr = '{32'hC040_0000, 32'hBFC0_0000, 32'hC000_0000, 32'hC100_0000};
        send_frame("neg", fr, 4, 0);
        get_result("neg", 32'd1, 32'hBFC0_0000);

        // -0, +0, -0, -1
        fr = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hBF80_0000};
        send_frame("zero", fr, 4, 0);
        get_result("zero", 32'd1, 32'h0000_0000);

        // 7, 3 closed early by TLAST
        fr = '{32'h40E0_0000, 32'h4040_0000, 32'h0, 32'h0};
        send_frame("early", fr, 2, 0);
        get_result("early", 32'd0, 32'h40E0_0000);

        // 0.1, 0.2, 0.4, 0.3
        fr = '{32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3ECC_CCCD, 32'h3E99_999A};
        send_frame("restart", fr, 4, 0);
        get_result("restart", 32'd2, 32'h3ECC_CCCD);

        // Backpressure on the result, with a competing input beat offered meanwhile
        out_tready = 1'b0;
        fr = '{32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000};
        send_frame("bp", fr, 4, 0);
        in_tdata  = 32'h42C8_0000;
        in_tlast  = 1'b1;
        in_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_vld", 32'(out_tvalid), 32'd1);
            check_eq("bp_data", out_tdata, 32'd3);
`ifdef ARGMAX_VALUE_EN
            check_eq("bp_last", 32'(out_tlast), 32'd0);
`else
            check_eq("bp_last", 32'(out_tlast), 32'd1);
`endif
            check_eq("bp_in_rdy", 32'(in_tready), 32'd0);
        end
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
`ifdef ARGMAX_VALUE_EN
        tick();
        check_eq("bp_val", out_tdata, 32'h4140_0000);
        check_eq("bp_val_last", 32'(out_tlast), 32'd1);
`endif
        tick();
        check_eq("bp_done", 32'(out_tvalid), 32'd0);
        check_eq("bp_rdy_back", 32'(in_tready), 32'd1);

        // 1, 4, 2, 3 with three idle cycles between beats
        fr = '{32'h3F80_0000, 32'h4080_0000, 32'h4000_0000, 32'h4040_0000};
        send_frame("bubble", fr, 4, 3);
        get_result("bubble", 32'd1, 32'h4080_0000);
        seen = 0;
        repeat (5) begin
            tick();
            if (out_tvalid) seen++;
        end
        check_eq("bubble_extra", 32'(seen), 32'd0);

        // Reset in the middle of a frame discards it
        send_beat("rstmid", 32'h4110_0000, 1'b0);
        send_beat("rstmid", 32'h3F80_0000, 1'b0);
        aresetn = 1'b0;
        #1;
        check_eq("rstmid_in_rdy", 32'(in_tready), 32'd0);
        check_eq("rstmid_vld", 32'(out_tvalid), 32'd0);
        tick();
        check_eq("rstmid_data", out_tdata, 32'd0);
        check_eq("rstmid_last", 32'(out_tlast), 32'd0);
        aresetn = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (out_tvalid) seen++;
        end
        check_eq("rstmid_novld", 32'(seen), 32'd0);

        // 1, 2, 3, 0.5
        fr = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000};
        send_frame("postrst", fr, 4, 0);
        get_result("postrst", 32'd2, 32'h4040_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
